deserialize: RTL and testbench
==============================

Name: deserialize

Overview:
- Receive-side counterpart of the layer-output serializer: collects a contiguous stream of dataWidth-bit words and reassembles them into one numNeuron*dataWidth-bit parallel vector.
- Word 0 is the first word received and lands in bits [dataWidth-1:0]. Word k lands in bits [(k+1)*dataWidth-1 : k*dataWidth].
- Sits at the input of a downstream layer or result buffer. Presents each completed vector with a valid/ready handshake.

Parameters:
- dataWidth, 16, width of one serial word
- numNeuron, 30, words per frame; legal range >= 1
- gapTimeout, 8, consecutive idle (serial_valid=0) cycles tolerated mid-frame before the frame is aborted; 0 disables abort

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- serial_valid  input  1  serial_data is valid this cycle; no backpressure is possible
- serial_data  input  dataWidth  serial word
- parallel_ready  input  1  downstream accepts parallel_data
- parallel_valid  output  1  parallel_data holds a complete frame
- parallel_data  output  numNeuron*dataWidth  assembled frame
- frame_error  output  1  one-cycle pulse on abort or dropped word
- busy  output  1  high in COLLECT or OUTPUT

Behaviour:
- Reset: all outputs, the buffer, the counters and the gap timer are 0; state is IDLE. Reset applied mid-frame discards the partial frame with no error pulse.
- All outputs are registered.
- State IDLE:
  - serial_valid=1 writes serial_data to slot 0 and sets cnt=1.
  - Next state is COLLECT, or OUTPUT if numNeuron==1.
- State COLLECT:
  - serial_valid=1 writes slot cnt, increments cnt and clears the gap timer.
  - When the word for slot numNeuron-1 is written, the whole buffer is copied to parallel_data. parallel_valid=1 on the next cycle and the state moves to OUTPUT.
  - Latency: 1 cycle from sampling the last word to parallel_valid.
  - serial_valid=0 increments the gap timer.
  - When gapTimeout!=0 and the timer reaches gapTimeout: pulse frame_error, clear the buffer and cnt, return to IDLE. parallel_data keeps its previous frame.
- State OUTPUT:
  - parallel_valid=1 and parallel_data stay stable until parallel_ready=1.
  - The cycle after parallel_ready=1 is seen: parallel_valid=0, state is IDLE.
  - parallel_data holds the last completed frame until the next completion.
- Overrun: serial_valid=1 in OUTPUT, including the same cycle as parallel_ready, drops the word and pulses frame_error. The next frame starts only with a serial_valid seen in IDLE.
- Back-to-back frames: a word arriving the cycle after the handshake completes (state IDLE) starts a new frame normally.
- Widths:
  - cnt and gap timer are $clog2(numNeuron+1) and $clog2(gapTimeout+1) bits; minimum width 1.
  - The gap timer saturates and does not wrap.
- busy = (state != IDLE), registered alongside state.

Decomposition:
- Package deserialize_pkg:
  - state typedef enum {IDLE, COLLECT, OUTPUT}
  - count-width helper function, shared with the serializer bench
- One sub-module, gap_timer:
  - clear, tick and saturate logic
  - timeout flag output, gapTimeout parameter
  - when gapTimeout==0 it outputs a constant 0

Test Plan:
- Contiguous frame: dataWidth=16, numNeuron=4, words 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles, ready held 1 -> parallel_valid for 1 cycle, one cycle after the last word; parallel_data=0x0004_0003_0002_0001; frame_error stays 0.
- Backpressure: same frame with ready=0 for 5 cycles, then 1 -> valid and data held stable 6 cycles; valid drops the cycle after ready; busy is 0 afterwards.
- Gap tolerance and abort: gapTimeout=3.
  - 2 idle cycles between word 1 and word 2 -> frame completes normally.
  - 3 idle cycles after word 1 -> frame_error pulse, return to IDLE; the next 4-word frame 0xA..0xD assembles correctly.
- Overrun: serial_valid=1 while in OUTPUT with ready=0 -> frame_error pulse, parallel_data unchanged, no slot written.
- Loopback: serializer output drives this block, random 30x16-bit vector -> reassembled vector equals the input, 100 iterations.
- Async reset after 2 of 4 words -> outputs 0 immediately; a fresh full frame afterwards assembles correctly with no error.

Source files
------------

// File: rtl/deserialize_pkg.sv
// Shared types and helpers for the frame deserializer and its serializer counterpart.
package deserialize_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/deserialize_if.sv
// Serial-in / parallel-out bus bundle between a word source, the deserializer and its consumer.
interface deserialize_if #(
    parameter int unsigned dataWidth = 16,
    parameter int unsigned numNeuron = 30
) ();

    logic                           serial_valid;
    logic [dataWidth-1:0]           serial_data;
    logic                           parallel_ready;
    logic                           parallel_valid;
    logic [numNeuron*dataWidth-1:0] parallel_data;
    logic                           frame_error;
    logic                           busy;

    modport master (
        output serial_valid, serial_data, parallel_ready,
        input  parallel_valid, parallel_data, frame_error, busy
    );

    modport slave (
        input  serial_valid, serial_data, parallel_ready,
        output parallel_valid, parallel_data, frame_error, busy
    );

endinterface

// File: rtl/deserialize_gap_timer.sv
// Counts consecutive idle cycles inside a frame; flags the idle cycle that reaches gapTimeout.
module deserialize_gap_timer
    import deserialize_pkg::*;
#(
    parameter int unsigned gapTimeout = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic tick,
    output logic timeout_c
);

    localparam int unsigned TW = cnt_width(gapTimeout);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Saturating count; a zero timeout never advances and never fires.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (tick && (32'(timer_q) < gapTimeout)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    assign timeout_c = (gapTimeout != 0) && tick && !clear &&
                       ((32'(timer_q) + 32'd1) == gapTimeout);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/deserialize.sv
// Reassembles a contiguous stream of serial words into one parallel frame with valid/ready output.
module deserialize
    import deserialize_pkg::*;
#(
    parameter int unsigned dataWidth  = 16,
    parameter int unsigned numNeuron  = 30,
    parameter int unsigned gapTimeout = 8
) (
    input  logic          clk,
    input  logic          rstn,
    deserialize_if.slave  bus
);

    localparam int unsigned FW = numNeuron * dataWidth;
    localparam int unsigned CW = cnt_width(numNeuron);
    localparam logic [CW-1:0] LastIdx = CW'(numNeuron - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   buf_q, buf_d;
    logic [FW-1:0]   parallel_data_q, parallel_data_d;
    logic            parallel_valid_q, parallel_valid_d;
    logic            frame_error_q, frame_error_d;
    logic            busy_q, busy_d;

    logic [CW-1:0]   wr_idx_c;
    logic [FW-1:0]   wr_vec_c;
    logic            gap_clear_c;
    logic            gap_tick_c;
    logic            gap_timeout_c;

    // Buffer image with the incoming word placed in its slot.
    always_comb begin
        wr_idx_c = (state_q == IDLE) ? '0 : cnt_q;
        wr_vec_c = buf_q;
        for (int unsigned i = 0; i < numNeuron; i++) begin
            if (wr_idx_c == CW'(i)) begin
                wr_vec_c[i*dataWidth +: dataWidth] = bus.serial_data;
            end
        end
    end

    assign gap_tick_c  = (state_q == COLLECT) && !bus.serial_valid;
    assign gap_clear_c = (state_q != COLLECT) || bus.serial_valid;

    deserialize_gap_timer #(
        .gapTimeout (gapTimeout)
    ) u_gap_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (gap_clear_c),
        .tick      (gap_tick_c),
        .timeout_c (gap_timeout_c)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        buf_d            = buf_q;
        parallel_data_d  = parallel_data_q;
        parallel_valid_d = parallel_valid_q;
        frame_error_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.serial_valid) begin
                    buf_d = wr_vec_c;
                    if (numNeuron == 1) begin
                        parallel_data_d  = wr_vec_c;
                        parallel_valid_d = 1'b1;
                        cnt_d            = '0;
                        state_d          = OUTPUT;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.serial_valid) begin
                    buf_d = wr_vec_c;
                    if (cnt_q == LastIdx) begin
                        parallel_data_d  = wr_vec_c;
                        parallel_valid_d = 1'b1;
                        cnt_d            = '0;
                        state_d          = OUTPUT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (gap_timeout_c) begin
                    // Abandon the partial frame; the last good frame stays on the output.
                    frame_error_d = 1'b1;
                    buf_d         = '0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end
            end
            OUTPUT: begin
                // No backpressure on the serial side, so a word here is lost.
                if (bus.serial_valid) begin
                    frame_error_d = 1'b1;
                end
                if (bus.parallel_ready) begin
                    parallel_valid_d = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            buf_q            <= '0;
            parallel_data_q  <= '0;
            parallel_valid_q <= 1'b0;
            frame_error_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            buf_q            <= buf_d;
            parallel_data_q  <= parallel_data_d;
            parallel_valid_q <= parallel_valid_d;
            frame_error_q    <= frame_error_d;
            busy_q           <= busy_d;
        end
    end

    assign bus.parallel_valid = parallel_valid_q;
    assign bus.parallel_data  = parallel_data_q;
    assign bus.frame_error    = frame_error_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_deserialize.sv
// Scoreboard bench: a 4-word/gap-3 instance for directed cases and a 30-word instance for loopback.
module tb_deserialize;

    logic clk;
    logic rstn;

    deserialize_if #(.dataWidth(16), .numNeuron(4))  if_a ();
    deserialize_if #(.dataWidth(16), .numNeuron(30)) if_b ();

    deserialize #(.dataWidth(16), .numNeuron(4), .gapTimeout(3)) u_dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_a)
    );

    deserialize #(.dataWidth(16), .numNeuron(30), .gapTimeout(8)) u_dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if_b)
    );

    int checks = 0;
    int errors = 0;
    int err_seen_a = 0;
    int err_seen_b = 0;
    int err_exp_a  = 0;

    logic [63:0]  exp_a [$];
    logic [479:0] exp_b [$];

    logic         hold_a = 1'b0;
    logic [63:0]  held_a = '0;
    logic         hold_b = 1'b0;
    logic [479:0] held_b = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors sample on the falling edge, where inputs and outputs are settled for the next rising edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (hold_a) begin
                chk("hold_a_valid", 512'(if_a.parallel_valid), 512'(1'b1));
                chk("hold_a_data", 512'(if_a.parallel_data), 512'(held_a));
            end
            if (if_a.parallel_valid && if_a.parallel_ready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_a: got %0h expected no frame", if_a.parallel_data);
                end else begin
                    chk("frame_a", 512'(if_a.parallel_data), 512'(exp_a.pop_front()));
                end
            end
            if (if_a.frame_error) err_seen_a <= err_seen_a + 1;
        end
        hold_a <= rstn && if_a.parallel_valid && !if_a.parallel_ready;
        held_a <= if_a.parallel_data;
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (hold_b) begin
                chk("hold_b_data", 512'(if_b.parallel_data), 512'(held_b));
            end
            if (if_b.parallel_valid && if_b.parallel_ready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_b: got %0h expected no frame", if_b.parallel_data);
                end else begin
                    chk("frame_b", 512'(if_b.parallel_data), 512'(exp_b.pop_front()));
                end
            end
            if (if_b.frame_error) err_seen_b <= err_seen_b + 1;
        end
        hold_b <= rstn && if_b.parallel_valid && !if_b.parallel_ready;
        held_b <= if_b.parallel_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] d);
        if_a.serial_valid = v;
        if_a.serial_data  = d;
        tick();
    endtask

    task automatic drive_b(input logic v, input logic [15:0] d);
        if_b.serial_valid = v;
        if_b.serial_data  = d;
        tick();
    endtask

    // Four contiguous words; valid must appear exactly one cycle after the last one.
    task automatic send4(input logic [63:0] f);
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, f[k*16 +: 16]);
            if (k < 3) chk("early_valid", 512'(if_a.parallel_valid), 512'(1'b0));
        end
        if_a.serial_valid = 1'b0;
        chk("latency_valid", 512'(if_a.parallel_valid), 512'(1'b1));
        chk("latency_data", 512'(if_a.parallel_data), 512'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [479:0] v;

        rstn = 1'b0;
        if_a.serial_valid = 1'b0; if_a.serial_data = '0; if_a.parallel_ready = 1'b0;
        if_b.serial_valid = 1'b0; if_b.serial_data = '0; if_b.parallel_ready = 1'b0;
        #1;
        chk("rst_valid", 512'(if_a.parallel_valid), 512'(1'b0));
        chk("rst_data", 512'(if_a.parallel_data), 512'(0));
        chk("rst_ferr", 512'(if_a.frame_error), 512'(1'b0));
        chk("rst_busy", 512'(if_a.busy), 512'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // Contiguous frame, ready held high
        if_a.parallel_ready = 1'b1;
        exp_a.push_back(64'h0004_0003_0002_0001);
        send4(64'h0004_0003_0002_0001);
        chk("t1_busy", 512'(if_a.busy), 512'(1'b1));
        tick();
        chk("t1_valid_drop", 512'(if_a.parallel_valid), 512'(1'b0));
        chk("t1_busy_idle", 512'(if_a.busy), 512'(1'b0));
        repeat (2) tick();
        chk("t1_ferr_count", 512'(err_seen_a), 512'(err_exp_a));

        // Backpressure: ready low for 5 cycles after completion
        if_a.parallel_ready = 1'b0;
        exp_a.push_back(64'h0004_0003_0002_0001);
        send4(64'h0004_0003_0002_0001);
        for (int i = 0; i < 6; i++) begin
            chk("t2_valid_held", 512'(if_a.parallel_valid), 512'(1'b1));
            if_a.parallel_ready = (i == 5);
            tick();
        end
        chk("t2_valid_drop", 512'(if_a.parallel_valid), 512'(1'b0));
        chk("t2_busy", 512'(if_a.busy), 512'(1'b0));

        // Gap of 2 idle cycles is tolerated
        exp_a.push_back(64'h0044_0033_0022_0011);
        drive_a(1'b1, 16'h0011);
        drive_a(1'b1, 16'h0022);
        drive_a(1'b0, 16'h0000);
        drive_a(1'b0, 16'h0000);
        drive_a(1'b1, 16'h0033);
        drive_a(1'b1, 16'h0044);
        if_a.serial_valid = 1'b0;
        chk("t3a_valid", 512'(if_a.parallel_valid), 512'(1'b1));
        tick();
        repeat (2) tick();
        chk("t3a_ferr_count", 512'(err_seen_a), 512'(err_exp_a));

        // Gap of 3 idle cycles aborts; previous frame stays on the output
        drive_a(1'b1, 16'h0055);
        drive_a(1'b1, 16'h0066);
        drive_a(1'b0, 16'h0000);
        drive_a(1'b0, 16'h0000);
        chk("t3b_no_early_err", 512'(if_a.frame_error), 512'(1'b0));
        drive_a(1'b0, 16'h0000);
        err_exp_a++;
        chk("t3b_ferr", 512'(if_a.frame_error), 512'(1'b1));
        chk("t3b_busy", 512'(if_a.busy), 512'(1'b0));
        chk("t3b_data_kept", 512'(if_a.parallel_data), 512'(64'h0044_0033_0022_0011));
        exp_a.push_back(64'h000D_000C_000B_000A);
        send4(64'h000D_000C_000B_000A);
        tick();
        repeat (2) tick();
        chk("t3b_ferr_count", 512'(err_seen_a), 512'(err_exp_a));

        // Overrun while holding, then overrun on the handshake cycle
        if_a.parallel_ready = 1'b0;
        exp_a.push_back(64'h0404_0303_0202_0101);
        send4(64'h0404_0303_0202_0101);
        drive_a(1'b1, 16'hBEEF);
        err_exp_a++;
        chk("t4_ferr", 512'(if_a.frame_error), 512'(1'b1));
        chk("t4_valid", 512'(if_a.parallel_valid), 512'(1'b1));
        chk("t4_data", 512'(if_a.parallel_data), 512'(64'h0404_0303_0202_0101));
        if_a.parallel_ready = 1'b1;
        drive_a(1'b1, 16'hCAFE);
        err_exp_a++;
        if_a.serial_valid = 1'b0;
        chk("t4_ferr_hs", 512'(if_a.frame_error), 512'(1'b1));
        chk("t4_valid_drop", 512'(if_a.parallel_valid), 512'(1'b0));
        chk("t4_busy", 512'(if_a.busy), 512'(1'b0));
        exp_a.push_back(64'h0008_0007_0006_0005);
        send4(64'h0008_0007_0006_0005);
        tick();
        repeat (2) tick();
        chk("t4_ferr_count", 512'(err_seen_a), 512'(err_exp_a));

        // Asynchronous reset mid-frame
        drive_a(1'b1, 16'h0F01);
        drive_a(1'b1, 16'h0F02);
        if_a.serial_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 512'(if_a.parallel_valid), 512'(1'b0));
        chk("t5_rst_busy", 512'(if_a.busy), 512'(1'b0));
        chk("t5_rst_ferr", 512'(if_a.frame_error), 512'(1'b0));
        chk("t5_rst_data", 512'(if_a.parallel_data), 512'(0));
        tick();
        rstn = 1'b1;
        tick();
        exp_a.push_back(64'h2004_2003_2002_2001);
        send4(64'h2004_2003_2002_2001);
        tick();
        repeat (2) tick();
        chk("t5_ferr_count", 512'(err_seen_a), 512'(err_exp_a));

        // Loopback: serializer model feeds random 30-word frames back to back
        if_b.parallel_ready = 1'b1;
        for (int it = 0; it < 100; it++) begin
            for (int j = 0; j < 15; j++) v[j*32 +: 32] = $urandom;
            exp_b.push_back(v);
            for (int k = 0; k < 30; k++) drive_b(1'b1, v[k*16 +: 16]);
            if_b.serial_valid = 1'b0;
            chk("loop_valid", 512'(if_b.parallel_valid), 512'(1'b1));
            tick();
        end
        repeat (3) tick();
        chk("loop_ferr_count", 512'(err_seen_b), 512'(0));
        chk("exp_a_left", 512'(exp_a.size()), 512'(0));
        chk("exp_b_left", 512'(exp_b.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
